rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation RV32I core; replaces the direct combinational PC-to-IMEM connection.
- Issues requests to a variable-latency instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers up to FIFO_DEPTH instructions with their PCs and delivers them to decode over a valid/ready channel.
- Handles branch/jump redirects by flushing the buffer and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2, maximum in-flight IMEM requests, including those being dropped; at least 1 and at most FIFO_DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  IMEM accepts request.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid; in request order; never back-pressured.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken; one-cycle pulse.
- redirect_pc  input  XLEN  new PC; bits [1:0] ignored (treated as 0).
- inst_valid  output  1  decode-side instruction valid.
- inst_ready  input  1  decode accepts instruction.
- inst_data  output  32  instruction word.
- inst_pc  output  XLEN  PC of inst_data.
- busy  output  1  requests in flight or being dropped.

Behaviour:
- Reset (asynchronous, active-high): fetch_pc = RESET_PC; all buffer pointers, filled flags and drop_cnt = 0; imem_req_valid = 0, inst_valid = 0, busy = 0. IMEM is reset together with this block, so no responses arrive after reset.
- Buffer: circular array of {pc, data, filled} with three pointers:
  - tail: allocate on request handshake.
  - fill: next entry awaiting a response.
  - head: pop.
  - Pointers carry one extra wrap bit. occupancy = tail - head; outstanding = tail - fill.
- Request:
  - imem_req_valid = !redirect_valid && occupancy < FIFO_DEPTH && (outstanding + drop_cnt) < MAX_OUTSTANDING.
  - imem_req_addr = fetch_pc.
  - On handshake: write fetch_pc into buffer[tail] with filled = 0; tail++; fetch_pc += 4, wrapping modulo 2^XLEN.
  - The combinational path from redirect_valid to imem_req_valid is permitted.
- Response:
  - If drop_cnt > 0: discard the response; drop_cnt--.
  - Otherwise: buffer[fill].data = imem_rsp_data, filled = 1, fill++.
- Output:
  - inst_valid = occupancy != 0 && buffer[head].filled.
  - inst_data and inst_pc come from buffer[head].
  - Pop on inst_valid && inst_ready.
  - Minimum latency is request handshake + IMEM latency + 1 cycle (registered fill, then output).
- Redirect (highest priority):
  - Same edge: head = tail = fill = 0; all filled flags cleared; fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = drop_cnt + outstanding - (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is still a valid consumption.
  - No request is issued in the redirect cycle. Fetch from the new PC starts the next cycle.
- Full: when occupancy == FIFO_DEPTH, no requests; resume the cycle after a pop.
- busy = outstanding != 0 || drop_cnt != 0.
- No state machine beyond pointers and drop_cnt. Fetch is always active after reset.

Decomposition:
- Shared package rv32i_pkg holds:
  - fetch_entry_t struct {pc, data, filled}.
  - INSTR_BYTES = 4 constant.
  - RESET_PC default constant.
- One natural sub-module: fetch_buffer (pointer and fill/pop logic with parametrised depth). The request/drop control stays in the top.

Test Plan:
- Zero-wait IMEM (ready = 1, response next cycle), inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8… at one per cycle in steady state; data matches IMEM contents.
- inst_ready = 0 for 20 cycles -> exactly FIFO_DEPTH (4) requests issued, then imem_req_valid = 0; release -> in-order delivery of PCs 0x0–0xC, fetching resumes at 0x10.
- IMEM latency 3, MAX_OUTSTANDING = 2 -> never more than 2 unanswered requests; busy is high while any are pending.
- Redirect to 0x100 with 2 outstanding requests and 1 buffered entry -> buffered entry never appears on inst_*; the 2 late responses are discarded; next inst_pc = 0x100.
- Redirect pulse coincident with imem_rsp_valid and an inst handshake -> popped instruction counts; the response is dropped; drop_cnt is correct (no stale PC delivered).
- Redirect to 0x203 -> fetch address 0x200. Reset asserted mid-stream -> all outputs 0 immediately (asynchronous); first request after release uses RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the RV32I fetch front end
package rv32i_pkg;

  localparam int PKG_XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [PKG_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [31:0]         data;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular instruction buffer with tail/fill/head pointers
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fetch_buffer
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_alloc,
  input  logic [PKG_XLEN-1:0]      i_alloc_pc,
  input  logic                     i_fill,
  input  logic [31:0]              i_fill_data,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic [$clog2(DEPTH):0]   o_outstanding,
  output fetch_entry_t             o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  fetch_entry_t   r_mem [DEPTH];
  logic [PTR_W:0] r_head;
  logic [PTR_W:0] r_tail;
  logic [PTR_W:0] r_fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
    end else begin
      // alloc and fill never target the same slot: that needs outstanding == DEPTH, which blocks alloc
      if (i_alloc) begin
        r_mem[r_tail[PTR_W-1:0]].pc     <= i_alloc_pc;
        r_mem[r_tail[PTR_W-1:0]].filled <= 1'b0;
        r_tail <= r_tail + PTR_ONE;
      end
      if (i_fill) begin
        r_mem[r_fill[PTR_W-1:0]].data   <= i_fill_data;
        r_mem[r_fill[PTR_W-1:0]].filled <= 1'b1;
        r_fill <= r_fill + PTR_ONE;
      end
      if (i_pop) r_head <= r_head + PTR_ONE;
    end
  end

  assign o_occupancy   = r_tail - r_head;
  assign o_outstanding = r_tail - r_fill;
  assign o_head        = r_mem[r_head[PTR_W-1:0]];

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rtl/rv32i_fetch_unit.sv - instruction fetch front end with IMEM request and drop control
// Redirects flush the buffer and convert in-flight requests into responses to discard.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC),
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = FIFO_DEPTH[CNT_W:0];
  localparam logic [CNT_W:0] OUT_LIM   = MAX_OUTSTANDING[CNT_W:0];

  logic [XLEN-1:0]  r_fetch_pc;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [CNT_W-1:0] w_occupancy;
  logic [CNT_W-1:0] w_outstanding;
  logic [CNT_W:0]   w_inflight;
  logic [CNT_W-1:0] w_rsp_dec;
  fetch_entry_t     w_head;
  logic             w_req_fire;
  logic             w_fill;
  logic             w_pop;

  assign w_inflight = {1'b0, w_outstanding} + {1'b0, r_drop_cnt};
  assign w_rsp_dec  = {{(CNT_W-1){1'b0}}, imem_rsp_valid};

  assign imem_req_valid = !reset && !redirect_valid
                       && ({1'b0, w_occupancy} < DEPTH_LIM)
                       && (w_inflight < OUT_LIM);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // responses still owed to a flushed stream are swallowed before any fill
  assign w_fill = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

  assign inst_valid = (w_occupancy != '0) && w_head.filled;
  assign inst_data  = w_head.data;
  assign inst_pc    = XLEN'(w_head.pc);
  assign w_pop      = inst_valid && inst_ready;

  assign busy = (w_outstanding != '0) || (r_drop_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
      r_drop_cnt <= r_drop_cnt + w_outstanding - w_rsp_dec;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - w_rsp_dec;
    end
  end

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_buffer (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (redirect_valid),
    .i_alloc       (w_req_fire),
    .i_alloc_pc    (PKG_XLEN'(r_fetch_pc)),
    .i_fill        (w_fill),
    .i_fill_data   (imem_rsp_data),
    .i_pop         (w_pop),
    .o_occupancy   (w_occupancy),
    .o_outstanding (w_outstanding),
    .o_head        (w_head)
  );

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb/tb_rv32i_fetch_unit.sv - directed bench for rv32i_fetch_unit
// The IMEM model returns the bitwise inverse of the fetch address as the instruction word.
module tb_rv32i_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = -1;
  int n_fire = 0;
  int n_rsp = 0;

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] fire_addr[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_data[$];
  int          pop_cyc[$];

  always #5 clk = ~clk;

  rv32i_fetch_unit #(
    .XLEN            (32),
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
  );

  task automatic clear_model();
    q_addr.delete(); q_due.delete(); fire_addr.delete();
    pop_pc.delete(); pop_data.delete(); pop_cyc.delete();
    n_fire = 0; n_rsp = 0; cyc = 0; last_due = -1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; lat = 1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // one clock: observe handshakes at negedge, then drive the IMEM response for the next cycle
  task automatic cycle();
    int due;
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_addr.push_back(imem_req_addr); q_due.push_back(due);
      fire_addr.push_back(imem_req_addr); n_fire++;
    end
    if (inst_valid && inst_ready) begin
      pop_pc.push_back(inst_pc); pop_data.push_back(inst_data); pop_cyc.push_back(cyc);
    end
    if (imem_rsp_valid) n_rsp++;
    @(posedge clk);
    #1;
    cyc++;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = ~q_addr[0];
      void'(q_addr.pop_front()); void'(q_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL release_req_valid: got %b expected 1", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL release_req_addr: got %h expected 00000000", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    apply_reset();
    inst_ready = 1'b1;
    repeat (20) cycle();
    n_vec++; if (pop_pc.size() < 16) begin n_bad++; $display("FAIL stream_count: got %0d expected >=16", pop_pc.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'(4 * i);
      n_vec++; if (pop_pc[i] !== exp_pc) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pop_pc[i], exp_pc); end
      n_vec++; if (pop_data[i] !== ~exp_pc) begin n_bad++; $display("FAIL stream_data[%0d]: got %h expected %h", i, pop_data[i], ~exp_pc); end
      n_vec++; if (pop_cyc[i] !== 2 + i) begin n_bad++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, pop_cyc[i], 2 + i); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redirect_blocks_req: got %b expected 0", imem_req_valid); end
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] exp_pc;
    apply_reset();
    inst_ready = 1'b0;
    repeat (20) cycle();
    n_vec++; if (n_fire !== 4) begin n_bad++; $display("FAIL full_fires: got %0d expected 4", n_fire); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_req_valid: got %b expected 0", imem_req_valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy: got %b expected 0", busy); end
    inst_ready = 1'b1;
    for (int k = 0; k < 20 && pop_pc.size() < 5; k++) cycle();
    n_vec++; if (pop_pc.size() < 5) begin n_bad++; $display("FAIL full_drain_timeout: got %0d pops expected 5", pop_pc.size()); end
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'(4 * i);
      n_vec++; if (pop_pc[i] !== exp_pc) begin n_bad++; $display("FAIL full_pc[%0d]: got %h expected %h", i, pop_pc[i], exp_pc); end
    end
    n_vec++; if (fire_addr[4] !== 32'h10) begin n_bad++; $display("FAIL full_resume_addr: got %h expected 00000010", fire_addr[4]); end
  endtask

  task automatic test_latency3();
    int pend;
    int max_pend;
    logic [31:0] exp_pc;
    apply_reset();
    lat = 3; inst_ready = 1'b1; max_pend = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      pend = n_fire - n_rsp;
      if (pend > max_pend) max_pend = pend;
      n_vec++; if (busy !== (pend != 0)) begin n_bad++; $display("FAIL lat3_busy@%0d: got %b expected %b", cyc, busy, pend != 0); end
    end
    n_vec++; if (max_pend !== 2) begin n_bad++; $display("FAIL lat3_max_outstanding: got %0d expected 2", max_pend); end
    n_vec++; if (pop_pc.size() < 5) begin n_bad++; $display("FAIL lat3_count: got %0d expected >=5", pop_pc.size()); end
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'(4 * i);
      n_vec++; if (pop_pc[i] !== exp_pc) begin n_bad++; $display("FAIL lat3_pc[%0d]: got %h expected %h", i, pop_pc[i], exp_pc); end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    inst_ready = 1'b0;
    lat = 1; cycle();
    lat = 6; cycle(); cycle(); cycle();
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_bad++; $display("FAIL redir_buffered: got v=%b pc=%h expected v=1 pc=00000000", inst_valid, inst_pc); end
    n_vec++; if (n_fire - n_rsp !== 2) begin n_bad++; $display("FAIL redir_setup_outstanding: got %0d expected 2", n_fire - n_rsp); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL redir_busy_dropping: got %b expected 1", busy); end
    lat = 1; inst_ready = 1'b1;
    for (int k = 0; k < 30 && pop_pc.size() < 1; k++) cycle();
    n_vec++; if (pop_pc.size() < 1) begin n_bad++; $display("FAIL redir_timeout: got %0d pops expected 1", pop_pc.size()); end
    n_vec++; if (pop_pc[0] !== 32'h100) begin n_bad++; $display("FAIL redir_pc: got %h expected 00000100", pop_pc[0]); end
    n_vec++; if (pop_data[0] !== ~32'h100) begin n_bad++; $display("FAIL redir_data: got %h expected %h", pop_data[0], ~32'h100); end
  endtask

  task automatic test_redirect_coincident();
    apply_reset();
    inst_ready = 1'b0;
    lat = 1; cycle();
    lat = 3; cycle(); cycle(); cycle();
    n_vec++; if (imem_rsp_valid !== 1'b1 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL coin_setup: got rsp=%b inst=%b expected 1 1", imem_rsp_valid, inst_valid); end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect_valid = 1'b0; lat = 1;
    n_vec++; if (pop_pc.size() !== 1 || pop_pc[0] !== 32'h0) begin n_bad++; $display("FAIL coin_pop: got n=%0d pc=%h expected n=1 pc=00000000", pop_pc.size(), pop_pc[0]); end
    for (int k = 0; k < 20 && pop_pc.size() < 2; k++) cycle();
    n_vec++; if (pop_pc.size() < 2) begin n_bad++; $display("FAIL coin_timeout: got %0d pops expected 2", pop_pc.size()); end
    n_vec++; if (pop_pc[1] !== 32'h200) begin n_bad++; $display("FAIL coin_pc: got %h expected 00000200", pop_pc[1]); end
    n_vec++; if (pop_data[1] !== ~32'h200) begin n_bad++; $display("FAIL coin_data: got %h expected %h", pop_data[1], ~32'h200); end
    n_vec++; if (fire_addr[3] !== 32'h200) begin n_bad++; $display("FAIL coin_fetch_addr: got %h expected 00000200", fire_addr[3]); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    inst_ready = 1'b1;
    repeat (6) cycle();
    #2 reset = 1'b1;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_req_valid: got %b expected 0", imem_req_valid); end
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL mid_inst_valid: got %b expected 0", inst_valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_vec++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL mid_inst_pc: got %h expected 00000000", inst_pc); end
    clear_model();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL mid_restart: got v=%b addr=%h expected v=1 addr=00000000", imem_req_valid, imem_req_addr); end
    repeat (10) cycle();
    n_vec++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0) begin n_bad++; $display("FAIL mid_first_pc: got n=%0d pc=%h expected pc=00000000", pop_pc.size(), pop_pc[0]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_latency3();
    test_redirect();
    test_redirect_coincident();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
